// File: rtl/jmb_pkg.sv
// Shared definitions for the scanline controller: configuration register map
// and sequencer state encoding.
package jmb_pkg;

  localparam logic [2:0] CFG_SHIFT  = 3'd0;
  localparam logic [2:0] CFG_CO_A   = 3'd1;
  localparam logic [2:0] CFG_CO_B   = 3'd2;
  localparam logic [2:0] CFG_CO_C   = 3'd3;
  localparam logic [2:0] CFG_LWIDTH = 3'd4;
  localparam logic [2:0] CFG_LCOUNT = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    FILTER = 2'd2,
    DRAIN  = 2'd3
  } state_t;

endpackage

// File: rtl/jmb_sync_fifo.sv
// Registered synchronous FIFO with occupancy count; the head is presented
// from storage (no fall-through) and reads as zero while empty.
module jmb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_FULL);
  assign do_pop   = pop && !empty;
  // A push into a full FIFO is still taken when a pop frees the slot this cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jmb_scanline_ctrl.sv
// Frame sequencer for jmb_scanline_filter: holds filter configuration, walks
// each line through prime/filter phases under credit flow control, and
// buffers tagged results in an output FIFO.
module jmb_scanline_ctrl
  import jmb_pkg::*;
#(
  parameter int PIX_W      = 8,
  parameter int DIM_W      = 12,
  parameter int PRIME_PIX  = 2,
  parameter int FILTER_LAT = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [15:0]      cfg_wdata,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_eol,
  output logic             out_eof,
  output logic             f_enable,
  output logic             f_pixel_wr,
  output logic             f_pixel_filter,
  output logic [PIX_W-1:0] f_pixel_in,
  output logic [7:0]       f_shift,
  output logic [7:0]       f_co_A,
  output logic [7:0]       f_co_B,
  output logic [7:0]       f_co_C,
  input  logic [PIX_W-1:0] f_pixel_out,
  input  logic             f_valid
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [DIM_W-1:0] DIM_ONE    = DIM_W'(1);
  localparam logic [DIM_W-1:0] PRIME_MIN  = DIM_W'(PRIME_PIX);
  localparam logic [DIM_W-1:0] PRIME_LAST = DIM_W'(PRIME_PIX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W:0]   DEPTH_LIM  = (CNT_W + 1)'(FIFO_DEPTH);

  if (FIFO_DEPTH < FILTER_LAT + 1) begin : g_depth_check
    $error("FIFO_DEPTH must cover the filter latency plus one");
  end

  state_t state;
  state_t next_state;

  logic [7:0]       sh_shift, sh_co_a, sh_co_b, sh_co_c;
  logic [DIM_W-1:0] sh_width, sh_count;
  logic [7:0]       act_shift, act_co_a, act_co_b, act_co_c;
  logic [DIM_W-1:0] act_width, act_count;

  logic [DIM_W-1:0] col, row, out_col, out_row;
  logic [DIM_W-1:0] out_per_line;
  logic [CNT_W-1:0] inflight, fifo_count;
  logic [CNT_W:0]   credit_used;
  logic [PIX_W-1:0] fifo_head;
  logic             fifo_full, fifo_empty;
  logic             streaming, credit_ok, cfg_ok;
  logic             start_ok, start_bad, done_next;
  logic             push, pop, overflow;
  logic             inflight_inc, inflight_dec;
  logic             col_last, row_last, out_line_last;
  logic             unused_cfg_bits;

  assign unused_cfg_bits = ^cfg_wdata;

  assign busy        = (state != IDLE);
  assign streaming   = (state == PRIME) || (state == FILTER);
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
  assign credit_ok   = (credit_used < DEPTH_LIM);
  assign in_ready    = streaming && credit_ok;
  assign f_enable    = in_valid && in_ready;
  assign f_pixel_in  = f_enable ? in_pixel : '0;
  assign f_pixel_wr  = streaming;
  assign f_pixel_filter = (state == FILTER);

  assign f_shift = act_shift;
  assign f_co_A  = act_co_a;
  assign f_co_B  = act_co_b;
  assign f_co_C  = act_co_c;

  assign cfg_ok   = (sh_width > PRIME_MIN) && (sh_count != '0);
  assign col_last = (col == act_width - DIM_ONE);
  assign row_last = (row == act_count - DIM_ONE);

  // Results arriving while idle belong to an aborted frame and are discarded.
  assign push         = f_valid && (state != IDLE);
  assign pop          = out_valid && out_ready;
  assign overflow     = push && fifo_full && !pop;
  assign inflight_inc = f_enable && (state == FILTER);
  assign inflight_dec = push && (inflight != '0);

  assign out_valid     = !fifo_empty;
  assign out_pixel     = fifo_head;
  assign out_per_line  = act_width - PRIME_MIN;
  assign out_line_last = (out_col == out_per_line - DIM_ONE);
  assign out_eol       = out_valid && out_line_last;
  assign out_eof       = out_eol && (out_row == act_count - DIM_ONE);

  jmb_sync_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (f_pixel_out),
    .pop       (pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The frame ends on the pop of its last result, so done and the fall of
  // busy land together in the following cycle.
  always_comb begin
    next_state = state;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            start_ok   = 1'b1;
            next_state = PRIME;
          end else begin
            start_bad  = 1'b1;
          end
        end
      end
      PRIME: begin
        if (f_enable && (col == PRIME_LAST)) begin
          next_state = FILTER;
        end
      end
      FILTER: begin
        if (f_enable && col_last) begin
          next_state = row_last ? DRAIN : PRIME;
        end
      end
      DRAIN: begin
        if ((inflight == '0) && (fifo_empty || (pop && (fifo_count == CNT_ONE)))) begin
          next_state = IDLE;
          done_next  = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sh_shift <= '0;
      sh_co_a  <= '0;
      sh_co_b  <= '0;
      sh_co_c  <= '0;
      sh_width <= '0;
      sh_count <= '0;
    end else if (cfg_we) begin
      case (cfg_addr)
        CFG_SHIFT:  sh_shift <= cfg_wdata[7:0];
        CFG_CO_A:   sh_co_a  <= cfg_wdata[7:0];
        CFG_CO_B:   sh_co_b  <= cfg_wdata[7:0];
        CFG_CO_C:   sh_co_c  <= cfg_wdata[7:0];
        CFG_LWIDTH: sh_width <= cfg_wdata[DIM_W-1:0];
        CFG_LCOUNT: sh_count <= cfg_wdata[DIM_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      act_shift <= '0;
      act_co_a  <= '0;
      act_co_b  <= '0;
      act_co_c  <= '0;
      act_width <= '0;
      act_count <= '0;
      col       <= '0;
      row       <= '0;
      out_col   <= '0;
      out_row   <= '0;
      inflight  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= done_next;
      err  <= err | start_bad | overflow;
      if (start_ok) begin
        act_shift <= sh_shift;
        act_co_a  <= sh_co_a;
        act_co_b  <= sh_co_b;
        act_co_c  <= sh_co_c;
        act_width <= sh_width;
        act_count <= sh_count;
        col       <= '0;
        row       <= '0;
        out_col   <= '0;
        out_row   <= '0;
        inflight  <= '0;
      end else begin
        if (f_enable) begin
          if ((state == FILTER) && col_last) begin
            col <= '0;
            row <= row + DIM_ONE;
          end else begin
            col <= col + DIM_ONE;
          end
        end
        case ({inflight_inc, inflight_dec})
          2'b10:   inflight <= inflight + CNT_ONE;
          2'b01:   inflight <= inflight - CNT_ONE;
          default: inflight <= inflight;
        endcase
        if (pop) begin
          if (out_line_last) begin
            out_col <= '0;
            out_row <= out_row + DIM_ONE;
          end else begin
            out_col <= out_col + DIM_ONE;
          end
        end
      end
    end
  end

endmodule
